// File: rtl/omem_drain_pkg.sv
// Shared defaults and FSM encoding for the OMEM write-back drain.
package omem_drain_pkg;
  localparam int MAX_CORES        = 4;
  localparam int WB_WIDTH         = 32;
  localparam int OMEM_AW_DEF      = 10;
  localparam int OMEM_SIZE        = 1 << OMEM_AW_DEF;
  localparam int OMEM_STRIDE_LOG2 = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } drain_state_e;
endpackage

// File: rtl/omem_drain_scan.sv
// Lowest set mask bit at or above a starting index, with a found flag.
module omem_drain_scan #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] from_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  // Walk downward so the lowest qualifying bit is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && (IW'(i) >= from_i)) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/omem_drain.sv
// Walks selected cores in ascending order, copying each core's OMEM words
// to main memory through a request/acknowledge write port.
module omem_drain
  import omem_drain_pkg::*;
#(
  parameter int CORES       = MAX_CORES,
  parameter int WIDTH       = WB_WIDTH,
  parameter int OMEM_AW     = OMEM_AW_DEF,
  parameter int STRIDE_LOG2 = OMEM_STRIDE_LOG2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iStart,
  input  logic [CORES-1:0]         iCoreMask,
  input  logic [OMEM_AW:0]         iWordCount,
  input  logic [WIDTH-1:0]         iBaseAddress,
  output logic [OMEM_AW-1:0]       oOMEM_ReadAddress,
  output logic [CORES-1:0]         oOMEM_Select,
  input  logic [CORES*WIDTH-1:0]   iOMEM_ReadData,
  output logic                     oMEM_WriteRequest,
  output logic [WIDTH-1:0]         oMEM_WriteAddress,
  output logic [WIDTH-1:0]         oMEM_WriteData,
  input  logic                     iMEM_WriteAck,
  output logic                     oBusy,
  output logic                     oDone
);
  // One extra bit so the core index can step past the last core and stop.
  localparam int CIW = $clog2(CORES) + 1;
  localparam logic [OMEM_AW:0] DEPTH = {1'b1, {OMEM_AW{1'b0}}};
  localparam logic [OMEM_AW:0] ONE   = (OMEM_AW + 1)'(1);

  drain_state_e       state_q, state_d;
  logic [CORES-1:0]   mask_q, mask_d;
  logic [OMEM_AW:0]   count_q, count_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [CIW-1:0]     core_q, core_d;
  logic [OMEM_AW-1:0] word_q, word_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic               scan_found;
  logic [CIW-1:0]     scan_idx;
  logic [WIDTH-1:0]   rd_slice;
  logic [CORES-1:0]   core_onehot;

  omem_drain_scan #(.N(CORES), .IW(CIW)) u_scan (
    .mask_i  (mask_q),
    .from_i  (core_q),
    .found_o (scan_found),
    .idx_o   (scan_idx)
  );

  always_comb begin
    rd_slice    = '0;
    core_onehot = '0;
    for (int i = 0; i < CORES; i++) begin
      if (core_q == CIW'(i)) begin
        rd_slice       = iOMEM_ReadData[i*WIDTH +: WIDTH];
        core_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    base_d  = base_q;
    core_d  = core_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          mask_d  = iCoreMask;
          count_d = (iWordCount > DEPTH) ? DEPTH : iWordCount;
          base_d  = iBaseAddress;
          core_d  = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_found && (count_q != '0)) begin
          core_d  = scan_idx;
          word_d  = '0;
          state_d = ST_RD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        data_d  = rd_slice;
        addr_d  = base_q + (WIDTH'(core_q) << STRIDE_LOG2) + WIDTH'(word_q);
        state_d = ST_WR;
      end
      ST_WR: begin
        if (iMEM_WriteAck) begin
          if (({1'b0, word_q} + ONE) < count_q) begin
            word_d  = word_q + 1'b1;
            state_d = ST_RD;
          end else begin
            mask_d  = mask_q & ~core_onehot;
            core_d  = core_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      count_q <= '0;
      base_q  <= '0;
      core_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      base_q  <= base_d;
      core_q  <= core_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign oOMEM_ReadAddress = (state_q == ST_RD) ? word_q : '0;
  assign oOMEM_Select      = (state_q == ST_RD) ? core_onehot : '0;
  assign oMEM_WriteRequest = (state_q == ST_WR);
  assign oMEM_WriteAddress = addr_q;
  assign oMEM_WriteData    = data_q;
  assign oBusy             = (state_q != ST_IDLE);
  assign oDone             = (state_q == ST_DONE);
endmodule

// File: tb/tb_omem_drain.sv
// Directed bench for omem_drain with a 1-cycle-latency OMEM model and ack driver.
module tb_omem_drain;
  logic         Clock = 1'b0;
  logic         Reset;
  logic         iStart;
  logic [3:0]   iCoreMask;
  logic [10:0]  iWordCount;
  logic [31:0]  iBaseAddress;
  logic [9:0]   oOMEM_ReadAddress;
  logic [3:0]   oOMEM_Select;
  logic [127:0] iOMEM_ReadData;
  logic         oMEM_WriteRequest;
  logic [31:0]  oMEM_WriteAddress;
  logic [31:0]  oMEM_WriteData;
  logic         iMEM_WriteAck;
  logic         oBusy;
  logic         oDone;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  omem_drain dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .iStart            (iStart),
    .iCoreMask         (iCoreMask),
    .iWordCount        (iWordCount),
    .iBaseAddress      (iBaseAddress),
    .oOMEM_ReadAddress (oOMEM_ReadAddress),
    .oOMEM_Select      (oOMEM_Select),
    .iOMEM_ReadData    (iOMEM_ReadData),
    .oMEM_WriteRequest (oMEM_WriteRequest),
    .oMEM_WriteAddress (oMEM_WriteAddress),
    .oMEM_WriteData    (oMEM_WriteData),
    .iMEM_WriteAck     (iMEM_WriteAck),
    .oBusy             (oBusy),
    .oDone             (oDone)
  );

  function automatic logic [31:0] wdat(int c, int w);
    return 32'hA000_0000 | (32'(c) << 16) | 32'(w);
  endfunction

  // OMEM model: only the selected core returns valid data, one cycle later.
  logic [31:0] rdq [4];
  always @(posedge Clock) begin
    for (int c = 0; c < 4; c++)
      rdq[c] <= oOMEM_Select[c] ? wdat(c, int'(oOMEM_ReadAddress)) : 32'hBAD0_0000;
  end
  assign iOMEM_ReadData = {rdq[3], rdq[2], rdq[1], rdq[0]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [3:0] m, input logic [10:0] cnt, input logic [31:0] base,
                     input int dly, input string tag);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] ha, hd;
    int eff, nwr, wt, last_ack, t_first, t_done, nbusy;
    eff = (cnt > 11'd1024) ? 1024 : int'(cnt);
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int w = 0; w < eff; w++) begin
          ea.push_back(base + (32'(c) << 12) + 32'(w));
          ed.push_back(wdat(c, w));
        end
    @(negedge Clock);
    iStart = 1'b1; iCoreMask = m; iWordCount = cnt; iBaseAddress = base;
    nwr = 0; wt = 0; last_ack = -1; t_first = -1; t_done = -1; nbusy = 0;
    ha = '0; hd = '0;
    for (int k = 1; k < 20000 && t_done < 0; k++) begin
      @(negedge Clock);
      iStart = 1'b0;
      iMEM_WriteAck = 1'b0;
      if (oBusy) nbusy++;
      if (oDone) t_done = k;
      if (oMEM_WriteRequest) begin
        if (t_first < 0) t_first = k;
        if (wt == 0) begin
          ha = oMEM_WriteAddress; hd = oMEM_WriteData;
          if (nwr < ea.size()) begin
            chk({tag, "_addr"}, oMEM_WriteAddress, ea[nwr]);
            chk({tag, "_data"}, oMEM_WriteData, ed[nwr]);
          end else begin
            chk({tag, "_extra_wr"}, 64'(nwr), 64'(ea.size()));
          end
        end else begin
          chk({tag, "_addr_stable"}, oMEM_WriteAddress, ha);
          chk({tag, "_data_stable"}, oMEM_WriteData, hd);
        end
        if (wt == dly) begin
          iMEM_WriteAck = 1'b1; nwr++; wt = 0; last_ack = k;
        end else begin
          wt++;
        end
      end else if (dly > 0) begin
        iMEM_WriteAck = 1'b1;  // stray ack outside WR must be ignored
      end
    end
    iMEM_WriteAck = 1'b0;
    chk({tag, "_done_seen"}, 64'(t_done >= 0), 64'(1));
    chk({tag, "_nwrites"}, 64'(nwr), 64'(ea.size()));
    if (ea.size() == 0) begin
      chk({tag, "_done_cyc"}, 64'(t_done), 64'(2));
      chk({tag, "_busy_cyc"}, 64'(nbusy), 64'(2));
      chk({tag, "_no_req"}, 64'(t_first), 64'(-1));
    end else begin
      chk({tag, "_first_req"}, 64'(t_first), 64'(4));
      chk({tag, "_done_after_ack"}, 64'(t_done - last_ack), 64'(2));
    end
    @(negedge Clock);
    chk({tag, "_done_pulse"}, 64'(oDone), 64'(0));
    chk({tag, "_idle"}, 64'(oBusy), 64'(0));
  endtask

  task automatic reset_midrun();
    int t_req;
    @(negedge Clock);
    iStart = 1'b1; iCoreMask = 4'b0011; iWordCount = 11'd3; iBaseAddress = 32'h0000_0100;
    t_req = -1;
    for (int k = 1; k < 50 && t_req < 0; k++) begin
      @(negedge Clock);
      iStart = (k == 2);
      if (k == 2) begin iCoreMask = 4'b1000; iBaseAddress = 32'h0000_9000; end
      if (oMEM_WriteRequest) t_req = k;
    end
    iStart = 1'b0;
    chk("rst_req_seen", 64'(t_req), 64'(4));
    chk("rst_first_addr", oMEM_WriteAddress, 32'h0000_0100);
    chk("rst_first_data", oMEM_WriteData, wdat(0, 0));
    @(negedge Clock);
    @(negedge Clock);
    chk("rst_req_held", 64'(oMEM_WriteRequest), 64'(1));
    Reset = 1'b0;
    #1;
    chk("rst_req_drop", 64'(oMEM_WriteRequest), 64'(0));
    chk("rst_busy", 64'(oBusy), 64'(0));
    chk("rst_done", 64'(oDone), 64'(0));
    chk("rst_waddr", oMEM_WriteAddress, 32'h0);
    chk("rst_wdata", oMEM_WriteData, 32'h0);
    chk("rst_sel", 64'(oOMEM_Select), 64'(0));
    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      chk("post_rst_idle", 64'({oBusy, oMEM_WriteRequest, oDone}), 64'(0));
    end
  endtask

  initial begin
    Reset = 1'b0; iStart = 1'b0; iCoreMask = '0; iWordCount = '0;
    iBaseAddress = '0; iMEM_WriteAck = 1'b0;
    #1;
    chk("reset_outs", 64'({oBusy, oDone, oMEM_WriteRequest, oOMEM_Select, oOMEM_ReadAddress}), 64'(0));
    chk("reset_wr", {oMEM_WriteAddress, oMEM_WriteData}, 64'(0));
    repeat (2) @(negedge Clock);
    Reset = 1'b1;

    run(4'b0101, 11'd2,    32'h0000_1000, 0, "imm");
    run(4'b0101, 11'd2,    32'h0000_1000, 5, "dly");
    run(4'b0000, 11'd2,    32'h0000_1000, 0, "empty");
    run(4'b1111, 11'd0,    32'h0000_1000, 0, "cnt0");
    run(4'b1000, 11'd1,    32'h0000_0000, 0, "core3");
    run(4'b0001, 11'd1025, 32'h2000_0000, 0, "clamp");
    run(4'b0001, 11'd2,    32'hFFFF_FFFF, 0, "wrap");
    reset_midrun();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
